// File: rtl/misao_mem_responder.sv
// misao_mem_responder: byte RAM plus memory-mapped TX FIFO for a small core.
//
// Two phases: LOAD (core held in reset, loader fills RAM) and RUN (core
// owns the bus). The core sees:
//   0x0000 .. MEM_DEPTH-1 : RAM, write-through at the clock edge, read combinationally
//   0x7FFE                : status {5'b0, wp_fault, ovf, full}; any write clears the sticky bits
//   0x7FFF                : write pushes a byte into the TX FIFO
// The TX FIFO drains through a valid/ready port.
//
// Optional feature: define MISAO_MEM_WPROT_EN to block core writes below
// WP_LIMIT. A blocked write is dropped and sets sticky wp_fault. Loader
// writes are never blocked.

module misao_mem_responder #(
  parameter int MEM_DEPTH  = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int WP_LIMIT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  // core side
  input  logic        mem_enable_read,
  input  logic        mem_enable_write,
  input  logic [14:0] mem_addr,
  input  logic        mem_rw,
  input  logic [7:0]  mem_data_out,
  output logic [7:0]  mem_data_in,
  output logic        core_rst,
  // loader side
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [14:0] ld_addr,
  input  logic [7:0]  ld_data,
  input  logic        ld_done,
  // TX stream
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  // The RAM limit is held in 16 bits so that a full 32 KiB RAM still compares correctly.
  localparam logic [15:0] MEM_LIMIT = 16'(MEM_DEPTH);
  localparam logic [14:0] STAT_ADDR = 15'h7FFE;
  localparam logic [14:0] TX_ADDR   = 15'h7FFF;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Storage arrays.
  logic [7:0] mem_q  [MEM_DEPTH];
  logic [7:0] fifo_q [FIFO_DEPTH];

  // FIFO pointers carry one extra wrap bit, so full and empty stay distinct.
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d;
  logic        wp_fault;

  // Decoded controls.
  logic in_load, in_run;
  logic ld_in_range, core_in_range;
  logic wp_hit;
  logic ld_we, core_we;
  logic push, push_ok, pop, stat_clr;
  logic fifo_full, fifo_empty;

  // Ignored inputs are collected here so that nothing is left dangling.
  logic unused_inputs;
  assign unused_inputs = ^{mem_rw, mem_enable_read};

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register: reset always returns to LOAD.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  // Next state and phase outputs; ld_done ends LOAD even with a write in the same cycle.
  // NOTE: every output gets a default first; a path that leaves a variable
  // unassigned in always_comb infers a latch.
  always_comb begin
    state_d  = state_q;
    core_rst = 1'b0;
    ld_ready = 1'b0;
    in_load  = 1'b0;
    in_run   = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        core_rst = 1'b1;
        ld_ready = 1'b1;
        in_load  = 1'b1;
        if (ld_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        in_run = 1'b1;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------

  // Range checks, write enables and FIFO handshakes.
  always_comb begin
    ld_in_range   = ({1'b0, ld_addr}  < MEM_LIMIT);
    core_in_range = ({1'b0, mem_addr} < MEM_LIMIT);
`ifdef MISAO_MEM_WPROT_EN
    wp_hit        = core_in_range && ({1'b0, mem_addr} < 16'(WP_LIMIT));
`else
    wp_hit        = 1'b0;
`endif
    ld_we    = in_load && ld_valid && ld_ready && ld_in_range;
    core_we  = in_run && mem_enable_write && core_in_range && !wp_hit;
    push     = in_run && mem_enable_write && !core_in_range && (mem_addr == TX_ADDR);
    stat_clr = in_run && mem_enable_write && !core_in_range && (mem_addr == STAT_ADDR);

    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    pop        = !fifo_empty && tx_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    push_ok    = push && (!fifo_full || pop);
  end

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------

  // RAM write port: the loader writes in LOAD and the core writes in RUN.
  // NOTE: storage arrays are deliberately not reset; RAM contents must survive
  // rst, and a reset on a large array prevents mapping it onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (ld_we)        mem_q[ld_addr[AW-1:0]]  <= ld_data;
      else if (core_we) mem_q[mem_addr[AW-1:0]] <= mem_data_out;
    end
  end

  // Zero-latency read mux: RAM, then status, otherwise zero.
  always_comb begin
    mem_data_in = 8'h00;
    if (core_in_range)
      mem_data_in = mem_q[mem_addr[AW-1:0]];
    else if (mem_addr == STAT_ADDR)
      mem_data_in = {5'b0, wp_fault, ovf_q, fifo_full};
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------

  // Next pointer and overflow values; a status write clears the sticky overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (PW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
    ovf_d    = ovf_q;
    if (stat_clr)            ovf_d = 1'b0;
    else if (push && !push_ok) ovf_d = 1'b1;
  end

  // Pointer and flag registers; reset flushes any undelivered bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) fifo_q[wr_ptr_q[PW-1:0]] <= mem_data_out;
  end

  // The head byte is forced to zero when the FIFO is empty, so it is defined after reset.
  always_comb begin
    tx_valid = !fifo_empty;
    tx_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q[PW-1:0]];
  end

  // ---------------------------------------------------------------------------
  // Write protection
  // ---------------------------------------------------------------------------

`ifdef MISAO_MEM_WPROT_EN
  logic wp_fault_q, wp_fault_d;

  // Sticky fault on a blocked core write; a status write clears it.
  always_comb begin
    wp_fault_d = wp_fault_q;
    if (stat_clr)                         wp_fault_d = 1'b0;
    else if (in_run && mem_enable_write && wp_hit) wp_fault_d = 1'b1;
  end

  // Fault flag register.
  always_ff @(posedge clk) begin
    if (rst) wp_fault_q <= 1'b0;
    else     wp_fault_q <= wp_fault_d;
  end

  assign wp_fault = wp_fault_q;
`else
  // Without protection every RAM byte is core-writable and the fault bit reads zero.
  logic [15:0] unused_wp_limit;
  assign unused_wp_limit = 16'(WP_LIMIT);
  assign wp_fault        = 1'b0;
`endif

endmodule

// File: tb/tb_misao_mem_responder.sv
// Testbench for misao_mem_responder. Directed vectors drive the DUT. TX
// bytes are scoreboarded: each accepted push queues its expected byte, and
// a monitor pops the queue on every handshake.

module tb_misao_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_enable_read, mem_enable_write, mem_rw;
  logic [14:0] mem_addr;
  logic [7:0]  mem_data_out, mem_data_in;
  logic        core_rst;
  logic        ld_valid, ld_ready, ld_done;
  logic [14:0] ld_addr;
  logic [7:0]  ld_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  misao_mem_responder dut (
    .clk              (clk),
    .rst              (rst),
    .mem_enable_read  (mem_enable_read),
    .mem_enable_write (mem_enable_write),
    .mem_addr         (mem_addr),
    .mem_rw           (mem_rw),
    .mem_data_out     (mem_data_out),
    .mem_data_in      (mem_data_in),
    .core_rst         (core_rst),
    .ld_valid         (ld_valid),
    .ld_ready         (ld_ready),
    .ld_addr          (ld_addr),
    .ld_data          (ld_data),
    .ld_done          (ld_done),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .tx_data          (tx_data)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string name, input logic [14:0] addr, input logic [7:0] exp);
    mem_addr = addr;
    #1;
    check(name, 16'(mem_data_in), 16'(exp));
  endtask

  task automatic core_wr(input logic [14:0] addr, input logic [7:0] data);
    mem_enable_write = 1'b1;
    mem_addr         = addr;
    mem_data_out     = data;
    tick();
    mem_enable_write = 1'b0;
  endtask

  // Core write to the TX port; an expected byte is queued only when the push is accepted.
  task automatic tx_push(input logic [7:0] data, input bit accepted);
    if (accepted) exp_q.push_back(data);
    core_wr(15'h7FFF, data);
  endtask

  task automatic ld_wr(input logic [14:0] addr, input logic [7:0] data, input logic done);
    ld_valid = 1'b1;
    ld_addr  = addr;
    ld_data  = data;
    ld_done  = done;
    tick();
    ld_valid = 1'b0;
    ld_done  = 1'b0;
  endtask

  // Bounded wait for the FIFO to empty, then confirm the scoreboard is empty too.
  task automatic drain(input string name);
    for (int i = 0; i < 20; i++) begin
      if (!tx_valid) break;
      tick();
    end
    check({name, "_timeout"}, 16'(tx_valid), 16'd0);
    check({name, "_sb_empty"}, 16'(exp_q.size()), 16'd0);
  endtask

  // Monitor: a handshake seen here pops at the next rising edge.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got 0x%0h, expected no byte", tx_data);
      end else begin
        check("tx_byte", 16'(tx_data), 16'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1;
    mem_enable_read = 1'b0; mem_enable_write = 1'b0; mem_rw = 1'b0;
    mem_addr = '0; mem_data_out = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    tx_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state.
    check("rst_core_rst", 16'(core_rst), 16'd1);
    check("rst_ld_ready", 16'(ld_ready), 16'd1);
    check("rst_tx_valid", 16'(tx_valid), 16'd0);
    check("rst_tx_data",  16'(tx_data),  16'd0);
    read_chk("rst_status", 15'h7FFE, 8'h00);

    // LOAD phase. Core writes are ignored, and an out-of-range loader write must not alias RAM[0].
    ld_wr(15'h0000, 8'h00, 1'b0);
    ld_wr(15'h0001, 8'h41, 1'b0);
    core_wr(15'h0001, 8'hFF);
    ld_wr(15'h0010, 8'h3C, 1'b0);
    ld_wr(15'h0100, 8'hEE, 1'b0);
    read_chk("load_read_ram1", 15'h0001, 8'h41);
    check("load_core_rst", 16'(core_rst), 16'd1);
    ld_wr(15'h0002, 8'h5A, 1'b1);            // write and done together
    check("run_core_rst", 16'(core_rst), 16'd0);
    check("run_ld_ready", 16'(ld_ready), 16'd0);
    read_chk("ram2",       15'h0002, 8'h5A);
    read_chk("ram1",       15'h0001, 8'h41);
    read_chk("ram0_noalias", 15'h0000, 8'h00);

    // RUN: RAM write, then an out-of-range write and unmapped reads.
    core_wr(15'h0080, 8'h77);
    read_chk("ram80", 15'h0080, 8'h77);
    core_wr(15'h0100, 8'hCC);
    read_chk("ram0_after_oor", 15'h0000, 8'h00);
    read_chk("unmapped_100",   15'h0100, 8'h00);
    read_chk("unmapped_1234",  15'h1234, 8'h00);
    read_chk("read_txport",    15'h7FFF, 8'h00);

    // Write protection.
    core_wr(15'h0010, 8'hAA);
`ifdef MISAO_MEM_WPROT_EN
    read_chk("wp_ram10",  15'h0010, 8'h3C);
    read_chk("wp_status", 15'h7FFE, 8'h04);
    core_wr(15'h7FFE, 8'h5A);
    read_chk("wp_cleared", 15'h7FFE, 8'h00);
`else
    read_chk("nowp_ram10",  15'h0010, 8'hAA);
    read_chk("nowp_status", 15'h7FFE, 8'h00);
`endif

    // A read strobe on the TX port must not push anything.
    mem_enable_read = 1'b1;
    mem_addr = 15'h7FFF;
    tick();
    mem_enable_read = 1'b0;
    check("read_no_side_effect", 16'(tx_valid), 16'd0);

    // Overflow: five pushes into a four-entry FIFO.
    tx_push(8'h11, 1'b1);
    check("push_valid_latency", 16'(tx_valid), 16'd1);
    check("head_first",         16'(tx_data),  16'h11);
    tx_push(8'h22, 1'b1);
    tx_push(8'h33, 1'b1);
    tx_push(8'h44, 1'b1);
    tx_push(8'h55, 1'b0);
    read_chk("status_ovf_full", 15'h7FFE, 8'h03);
    check("head_stable", 16'(tx_data), 16'h11);
    core_wr(15'h7FFE, 8'h00);
    read_chk("status_full_only", 15'h7FFE, 8'h01);
    tx_ready = 1'b1;
    drain("drain1");
    tx_ready = 1'b0;

    // Full FIFO: a push and a pop in the same cycle both succeed, with no overflow.
    tx_push(8'hA1, 1'b1);
    tx_push(8'hA2, 1'b1);
    tx_push(8'hA3, 1'b1);
    tx_push(8'hA4, 1'b1);
    read_chk("status_full", 15'h7FFE, 8'h01);
    tx_ready = 1'b1;
    tx_push(8'h99, 1'b1);
    drain("drain2");
    read_chk("status_no_ovf", 15'h7FFE, 8'h00);
    tx_ready = 1'b0;

    // Reset in RUN flushes queued bytes.
    tx_push(8'hB1, 1'b0);
    tx_push(8'hB2, 1'b0);
    tx_push(8'hB3, 1'b0);
    check("queued_valid", 16'(tx_valid), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("flush_tx_valid", 16'(tx_valid), 16'd0);
    check("flush_tx_data",  16'(tx_data),  16'd0);
    check("flush_core_rst", 16'(core_rst), 16'd1);
    check("flush_ld_ready", 16'(ld_ready), 16'd1);
    tx_ready = 1'b1;
    repeat (3) tick();
    check("flush_stays_empty", 16'(tx_valid), 16'd0);
    read_chk("ram80_kept", 15'h0080, 8'h77);
    read_chk("ram2_kept",  15'h0002, 8'h5A);
    read_chk("status_after_rst", 15'h7FFE, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
